reg_file_mp: RTL

Parametrised multi-port integer register file for the RV32I pipeline, replacing the fixed 32×32, 2R/1W file. It provides NRD combinational read ports with write-first bypass and two prioritised write ports for the writeback and late-load paths. A per-register busy scoreboard supports hazard detection. A sequential clear engine zeroes the array one entry per cycle, so the storage can map to plain RAM without a per-bit async reset.

---
 rtl/reg_file_mp.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised integer register file for the RV32I pipeline.
// NRD combinational read ports with write-first bypass, two write ports
// (port 1 wins on an address collision), a per-register busy scoreboard
// and a one-entry-per-cycle clear sweep so the array needs no bit reset.
module reg_file_mp #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                clk_i,
    input  logic                rst_n,
    input  logic                clr_i,
    output logic                ready_o,
    input  logic [NRD*AW-1:0]   rs_addr_i,
    output logic [NRD*XLEN-1:0] rs_data_o,
    output logic [NRD-1:0]      rs_busy_o,
    input  logic                we0_i,
    input  logic                we1_i,
    input  logic [AW-1:0]       wa0_i,
    input  logic [AW-1:0]       wa1_i,
    input  logic [XLEN-1:0]     wd0_i,
    input  logic [XLEN-1:0]     wd1_i,
    input  logic                claim_i,
    input  logic [AW-1:0]       claim_addr_i
);

    localparam int              NREG     = 2 ** AW;
    localparam logic [AW-1:0]   LAST_IDX = {AW{1'b1}};
    localparam logic            HAS_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic [XLEN-1:0]   mem_q [NREG];

    logic              sweeping;
    logic              wr0_ok;
    logic              wr1_ok;
    logic              claim_ok;

    assign sweeping = (state_q == SWEEP);
    assign ready_o  = (state_q == IDLE);

    // Writes and claims only take effect in IDLE; entry 0 is read-only when hardwired.
    assign wr0_ok   = !sweeping && we0_i   && !(HAS_ZERO && (wa0_i == '0));
    assign wr1_ok   = !sweeping && we1_i   && !(HAS_ZERO && (wa1_i == '0));
    assign claim_ok = !sweeping && claim_i && !(HAS_ZERO && (claim_addr_i == '0));

    // Sweep sequencing: walk idx across every entry, clr_i (re)starts from 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            SWEEP: begin
                if (clr_i) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                idx_d   = '0;
            end
        endcase
    end

    // Busy scoreboard: commits clear, a same-cycle claim sets (new producer wins).
    always_comb begin
        busy_d = busy_q;
        if (sweeping) begin
            busy_d[idx_q] = 1'b0;
        end else begin
            if (wr0_ok) begin
                busy_d[wa0_i] = 1'b0;
            end
            if (wr1_ok) begin
                busy_d[wa1_i] = 1'b0;
            end
            if (claim_ok) begin
                busy_d[claim_addr_i] = 1'b1;
            end
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end
    end

    // Control state and scoreboard; reset forces a fresh sweep from entry 0.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    // Storage array without reset; port 1 is written last so it wins a collision.
    always_ff @(posedge clk_i) begin
        if (sweeping) begin
            mem_q[idx_q] <= '0;
        end else begin
            if (wr0_ok) begin
                mem_q[wa0_i] <= wd0_i;
            end
            if (wr1_ok) begin
                mem_q[wa1_i] <= wd1_i;
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   rd_addr;
        logic [XLEN-1:0] rd_data;

        assign rd_addr = rs_addr_i[gi*AW +: AW];

        // Read mux: zero register, then port-1 bypass, port-0 bypass, array.
        always_comb begin
            rd_data = mem_q[rd_addr];
            if (sweeping) begin
                rd_data = '0;
            end else if (HAS_ZERO && (rd_addr == '0)) begin
                rd_data = '0;
            end else if (we1_i && (wa1_i == rd_addr)) begin
                rd_data = wd1_i;
            end else if (we0_i && (wa0_i == rd_addr)) begin
                rd_data = wd0_i;
            end
        end

        assign rs_data_o[gi*XLEN +: XLEN] = rd_data;
        assign rs_busy_o[gi]              = !sweeping && busy_q[rd_addr];
    end

endmodule
